mega_ram_loader: RTL and testbench

MEGA_RAM_LOADER -- requirements
Module: mega_ram_loader

---
 rtl/mega_ram_loader.sv | 182 ++++++++++++++++++
 tb/tb_mega_ram_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mega_ram_loader.sv
// Streams parameter words into six RAM regions (W1,B1,W2,B2,W3,B3) in order, skipping empty regions.
// Optional running checksum output enabled by defining MEGA_RAM_LOADER_CHECKSUM_EN.
module mega_ram_loader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int DEPTH_W1 = 1024,
    parameter int DEPTH_B1 = 1024,
    parameter int DEPTH_W2 = 64,
    parameter int DEPTH_B2 = 64,
    parameter int DEPTH_W3 = 10,
    parameter int DEPTH_B3 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        region
`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int NREG = 6;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    function automatic int depth_of(input int idx);
        case (idx)
            0:       return DEPTH_W1;
            1:       return DEPTH_B1;
            2:       return DEPTH_W2;
            3:       return DEPTH_B2;
            4:       return DEPTH_W3;
            5:       return DEPTH_B3;
            default: return 0;
        endcase
    endfunction

    logic [1:0]        state_reg;
    logic [2:0]        region_reg;
    logic [ADDR_W-1:0] counter_reg;
    logic [5:0]        wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              done_reg;

    // Per-region static tables: which regions hold data and the index of their final word.
    logic [NREG-1:0]   nz;
    logic [ADDR_W-1:0] last_addr [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_region
            localparam int D = depth_of(gi);
            assign nz[gi]        = (D != 0);
            assign last_addr[gi] = (D == 0) ? '0 : ADDR_W'(D - 1);
        end
    endgenerate

    logic       first_found;
    logic [2:0] first_idx;
    logic       next_found;
    logic [2:0] next_idx;

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (nz[i]) begin
                first_found = 1'b1;
                first_idx   = 3'(i);
            end
            if (nz[i] && (i > int'(region_reg))) begin
                next_found = 1'b1;
                next_idx   = 3'(i);
            end
        end
    end

    logic is_last;
    logic start_accept;
    logic transfer;

    assign is_last      = (counter_reg == last_addr[region_reg]);
    assign start_accept = (state_reg == IDLE) && start && !abort;
    assign transfer     = (state_reg == LOAD) && in_valid && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            region_reg  <= '0;
            counter_reg <= '0;
            wr_en_reg   <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            wr_en_reg <= '0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_accept) begin
                        counter_reg <= '0;
                        if (first_found) begin
                            region_reg <= first_idx;
                            state_reg  <= LOAD;
                        end else begin
                            state_reg <= FINISH;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (in_valid) begin
                        wr_en_reg   <= 6'b000001 << region_reg;
                        wr_addr_reg <= counter_reg;
                        wr_data_reg <= in_data;
                        if (is_last) begin
                            counter_reg <= '0;
                            if (next_found) begin
                                region_reg <= next_idx;
                            end else begin
                                // done rises together with the final write strobe.
                                state_reg <= FINISH;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            counter_reg <= counter_reg + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (start_accept) begin
            checksum_reg <= '0;
        end else if (transfer) begin
            checksum_reg <= checksum_reg + 16'(in_data);
        end
    end

    assign checksum = checksum_reg;
`endif

    assign in_ready = (state_reg == LOAD);
    assign busy     = (state_reg == LOAD);
    assign done     = done_reg;
    assign region   = region_reg;
    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;

endmodule

// File: tb/tb_mega_ram_loader.sv
// Drives three loader instances (mixed, sparse and all-empty region maps) with shared stimulus
// and compares every output each cycle against a flattened write-slot reference model.
module tb_mega_ram_loader;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    always #5 clk = ~clk;

    logic        in_ready_o [NI];
    logic        busy_o     [NI];
    logic        done_o     [NI];
    logic [5:0]  wr_en_o    [NI];
    logic [15:0] wr_addr_o  [NI];
    logic [31:0] wr_data_o  [NI];
    logic [2:0]  region_o   [NI];
`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
    logic [15:0] cs_o       [NI];
`endif

    mega_ram_loader #(.DEPTH_W1(2), .DEPTH_B1(1), .DEPTH_W2(2), .DEPTH_B2(1), .DEPTH_W3(1), .DEPTH_B3(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o[0]), .wr_data(wr_data_o[0]), .wr_addr(wr_addr_o[0]), .wr_en(wr_en_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .region(region_o[0])
`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
        , .checksum(cs_o[0])
`endif
    );

    mega_ram_loader #(.DEPTH_W1(0), .DEPTH_B1(0), .DEPTH_W2(3), .DEPTH_B2(0), .DEPTH_W3(0), .DEPTH_B3(1)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o[1]), .wr_data(wr_data_o[1]), .wr_addr(wr_addr_o[1]), .wr_en(wr_en_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .region(region_o[1])
`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
        , .checksum(cs_o[1])
`endif
    );

    mega_ram_loader #(.DEPTH_W1(0), .DEPTH_B1(0), .DEPTH_W2(0), .DEPTH_B2(0), .DEPTH_W3(0), .DEPTH_B3(0)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o[2]), .wr_data(wr_data_o[2]), .wr_addr(wr_addr_o[2]), .wr_en(wr_en_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .region(region_o[2])
`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
        , .checksum(cs_o[2])
`endif
    );

    // Region depths of each instance above, in W1,B1,W2,B2,W3,B3 order.
    int dep [NI][6] = '{'{2, 1, 2, 1, 1, 1}, '{0, 0, 3, 0, 0, 1}, '{0, 0, 0, 0, 0, 0}};

    // Reference model: the whole load is the ordered list of (region, address) slots.
    int          slot_reg  [NI][$];
    int          slot_addr [NI][$];
    bit          m_load    [NI];
    bit          m_fin     [NI];
    int          m_k       [NI];
    logic [2:0]  m_region  [NI];
    logic [5:0]  e_wr_en   [NI];
    logic [15:0] e_addr    [NI];
    logic [31:0] e_data    [NI];
    bit          e_done    [NI];
    logic [15:0] m_cs      [NI];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_load[i] = 0; m_fin[i] = 0; m_k[i] = 0; m_region[i] = '0;
            e_wr_en[i] = '0; e_addr[i] = '0; e_data[i] = '0; e_done[i] = 0; m_cs[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            e_wr_en[i] = '0;
            e_done[i]  = 0;
            if (m_fin[i]) begin
                m_fin[i] = 0;
            end else if (!m_load[i]) begin
                if (start && !abort) begin
                    m_cs[i] = '0;
                    m_k[i]  = 0;
                    if (slot_reg[i].size() == 0) begin
                        m_fin[i]  = 1;
                        e_done[i] = 1;
                        $display("inst %0d: start with no regions -> done", i);
                    end else begin
                        m_load[i]   = 1;
                        m_region[i] = 3'(slot_reg[i][0]);
                    end
                end
            end else if (abort) begin
                m_load[i] = 0;
                $display("inst %0d: load aborted after %0d words", i, m_k[i]);
            end else if (in_valid) begin
                e_wr_en[i] = 6'(1 << slot_reg[i][m_k[i]]);
                e_addr[i]  = 16'(slot_addr[i][m_k[i]]);
                e_data[i]  = in_data;
                m_cs[i]    = m_cs[i] + in_data[15:0];
                m_k[i]++;
                if (m_k[i] == slot_reg[i].size()) begin
                    m_load[i] = 0;
                    m_fin[i]  = 1;
                    e_done[i] = 1;
                    $display("inst %0d: load complete, %0d words, last data 0x%0h", i, m_k[i], in_data);
                end else begin
                    m_region[i] = 3'(slot_reg[i][m_k[i]]);
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("wr_en[%0d]", i), 32'(wr_en_o[i]), 32'(e_wr_en[i]));
            check($sformatf("wr_addr[%0d]", i), 32'(wr_addr_o[i]), 32'(e_addr[i]));
            check($sformatf("wr_data[%0d]", i), wr_data_o[i], e_data[i]);
            check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(e_done[i]));
            check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_load[i]));
            check($sformatf("in_ready[%0d]", i), 32'(in_ready_o[i]), 32'(m_load[i]));
            check($sformatf("region[%0d]", i), 32'(region_o[i]), 32'(m_region[i]));
`ifdef MEGA_RAM_LOADER_CHECKSUM_EN
            if (e_done[i] || rst)
                check($sformatf("checksum[%0d]", i), 32'(cs_o[i]), 32'(m_cs[i]));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit s, input bit a, input bit v, input logic [31:0] d);
        start = s; abort = a; in_valid = v; in_data = d;
        step();
    endtask

    // Reset is raised between edges so its asynchronous effect is visible before any clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++)
            for (int r = 0; r < 6; r++)
                for (int a = 0; a < dep[i][r]; a++) begin
                    slot_reg[i].push_back(r);
                    slot_addr[i].push_back(a);
                end
        model_reset();

        repeat (2) step();
        rst = 1'b0;
        drive(0, 0, 0, 0);

        // Eight consecutive words, valid held high.
        drive(1, 0, 0, 0);
        for (int w = 0; w < 8; w++) drive(0, 0, 1, 32'h10 + 32'(w));
        repeat (3) drive(0, 0, 0, 0);

        // Same load with valid toggling every cycle.
        drive(1, 0, 0, 0);
        for (int c = 0; c < 16; c++) drive(0, 0, (c % 2) == 0, 32'h10 + 32'(c / 2));
        repeat (3) drive(0, 0, 0, 0);

        // Abort after the third word, then a clean restart.
        drive(1, 0, 0, 0);
        for (int w = 0; w < 3; w++) drive(0, 0, 1, 32'h30 + 32'(w));
        drive(0, 1, 1, 32'hdead);
        repeat (2) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int w = 0; w < 10; w++) drive(0, 0, 1, 32'h40 + 32'(w));
        repeat (2) drive(0, 0, 0, 0);

        // start and abort together in idle: abort wins.
        drive(1, 1, 0, 0);
        repeat (2) drive(0, 0, 1, 32'h55);

        // start during LOAD ignored, then reset mid-load and restart from scratch.
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 32'h0000ffff);
        drive(1, 0, 1, 32'h00000002);
        drive(0, 0, 1, 32'h60);
        async_reset();
        drive(1, 0, 0, 0);
        for (int w = 0; w < 9; w++) drive(0, 0, 1, 32'h70 + 32'(w));
        repeat (2) drive(0, 0, 0, 0);

        // Randomized traffic with occasional mid-run resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(299) == 0) async_reset();
            else drive($urandom_range(7) == 0, $urandom_range(19) == 0,
                       $urandom_range(2) != 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
